// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ANCHO-bit ALU with valid/ready handshake on both
// sides. SUM/RES/AND/OR/XOR (and DIV/MOD by zero) answer one cycle after
// acceptance; PRO (shift-add) and DIV/MOD (restoring) iterate ANCHO cycles.
// Optional macro ALU_SIGNO_EN adds the Con_signo input for two's-complement
// operation; the default build is unsigned only.
module alu_secuencial #(
   parameter int ANCHO = 8
) (
   input  logic               Reloj,
   input  logic               Reset_n,
   input  logic [2:0]         Codigo_OP,
   input  logic [ANCHO-1:0]   Dato0,
   input  logic [ANCHO-1:0]   Dato1,
`ifdef ALU_SIGNO_EN
   input  logic               Con_signo,
`endif
   input  logic               En_valido,
   output logic               En_listo,
   output logic [2*ANCHO-1:0] Resultado,
   output logic               banderaA,
   output logic               banderaB,
   output logic               banderaC,
   output logic               Sal_valido,
   input  logic               Sal_listo
);
   localparam int ANCHO_CNT = $clog2(ANCHO + 1);
   localparam int W2        = 2 * ANCHO;

   typedef enum logic [2:0] {
      OP_SUM = 3'b000, OP_RES = 3'b001, OP_PRO = 3'b010, OP_DIV = 3'b011,
      OP_MOD = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
   } op_e;

   typedef enum logic [1:0] {REPOSO, CALCULO, ENTREGA} estado_e;

   estado_e              estado;
   op_e                  op_q;
   logic [ANCHO-1:0]     m_q;      // multiplicand (PRO) or divisor (DIV/MOD)
   logic [W2-1:0]        acc;      // {partial product, multiplier} or {remainder, quotient}
   logic [ANCHO_CNT-1:0] cnt;
   logic                 signo_q;
   logic                 neg_q;    // negate product / quotient at the end
   logic                 neg_r_q;  // negate remainder at the end
   logic                 ovf_q;    // most-negative / -1

   logic                 signo_in;
   op_e                  op_in;

`ifdef ALU_SIGNO_EN
   assign signo_in = Con_signo;
`else
   assign signo_in = 1'b0;
`endif
   assign op_in = op_e'(Codigo_OP);

   // Iterative datapaths work on magnitudes; signs are reapplied at the end.
   logic             neg0, neg1;
   logic [ANCHO-1:0] abs0, abs1;
   assign neg0 = signo_in & Dato0[ANCHO-1];
   assign neg1 = signo_in & Dato1[ANCHO-1];
   assign abs0 = neg0 ? -Dato0 : Dato0;
   assign abs1 = neg1 ? -Dato1 : Dato1;

   function automatic logic [W2-1:0] ext(input logic [ANCHO-1:0] v, input logic s);
      return {{ANCHO{s & v[ANCHO-1]}}, v};
   endfunction

   logic [ANCHO:0]  suma, resta;
   logic [W2-1:0]   res_inm;
   logic            fa_inm, fc_inm, itera;

   // Single-cycle results, computed straight from the presented operands.
   always_comb begin
      suma    = {neg0, Dato0} + {neg1, Dato1};
      resta   = {neg0, Dato0} - {neg1, Dato1};
      res_inm = '0;
      fa_inm  = 1'b0;
      fc_inm  = 1'b0;
      itera   = 1'b0;
      case (op_in)
         OP_SUM: begin
            // exact (ANCHO+1)-bit sum; zero-extended when unsigned
            res_inm = {{(ANCHO-1){signo_in & suma[ANCHO]}}, suma};
            fa_inm  = signo_in ? (suma[ANCHO] ^ suma[ANCHO-1]) : suma[ANCHO];
         end
         OP_RES: begin
            res_inm = signo_in ? {{(ANCHO-1){resta[ANCHO]}}, resta}
                               : {{ANCHO{1'b0}}, resta[ANCHO-1:0]};
            fa_inm  = signo_in ? (resta[ANCHO] ^ resta[ANCHO-1]) : resta[ANCHO];
         end
         OP_PRO:         itera = 1'b1;
         OP_DIV, OP_MOD: begin
            if (Dato1 == '0) fc_inm = 1'b1;
            else             itera  = 1'b1;
         end
         OP_AND:  res_inm = ext(Dato0 & Dato1, signo_in);
         OP_OR:   res_inm = ext(Dato0 | Dato1, signo_in);
         OP_XOR:  res_inm = ext(Dato0 ^ Dato1, signo_in);
         default: res_inm = '0;
      endcase
   end

   logic [ANCHO:0]   suma_it, despl, dif_it;
   logic [W2-1:0]    acc_nxt, res_it;
   logic [ANCHO-1:0] q_fin, r_fin;
   logic             fa_it;

   // One shift-add or restoring-division step, plus the sign fix-up applied
   // on the last step so the result lands in Resultado on that same edge.
   always_comb begin
      suma_it = {1'b0, acc[W2-1:ANCHO]} + (acc[0] ? {1'b0, m_q} : '0);
      despl   = {acc[W2-1:ANCHO], acc[ANCHO-1]};
      dif_it  = despl - {1'b0, m_q};
      if (op_q == OP_PRO)
         acc_nxt = {suma_it, acc[ANCHO-1:1]};
      else
         acc_nxt = {(dif_it[ANCHO] ? despl[ANCHO-1:0] : dif_it[ANCHO-1:0]),
                    acc[ANCHO-2:0], ~dif_it[ANCHO]};
      q_fin  = neg_q   ? -acc_nxt[ANCHO-1:0]  : acc_nxt[ANCHO-1:0];
      r_fin  = neg_r_q ? -acc_nxt[W2-1:ANCHO] : acc_nxt[W2-1:ANCHO];
      res_it = '0;
      fa_it  = 1'b0;
      case (op_q)
         OP_PRO: begin
            res_it = neg_q ? -acc_nxt : acc_nxt;
            fa_it  = signo_q ? (res_it[W2-1:ANCHO] != {ANCHO{res_it[ANCHO-1]}})
                             : (res_it[W2-1:ANCHO] != '0);
         end
         OP_DIV: begin
            res_it = ext(q_fin, signo_q);
            fa_it  = ovf_q;
         end
         OP_MOD:  res_it = ext(r_fin, signo_q);
         default: res_it = '0;
      endcase
   end

   // Control FSM: accept in REPOSO, iterate in CALCULO, hold result in ENTREGA.
   always_ff @(posedge Reloj) begin
      if (!Reset_n) begin
         estado     <= REPOSO;
         En_listo   <= 1'b1;
         Sal_valido <= 1'b0;
         Resultado  <= '0;
         banderaA   <= 1'b0;
         banderaB   <= 1'b0;
         banderaC   <= 1'b0;
         op_q       <= OP_SUM;
         m_q        <= '0;
         acc        <= '0;
         cnt        <= '0;
         signo_q    <= 1'b0;
         neg_q      <= 1'b0;
         neg_r_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (estado)
            REPOSO: begin
               if (En_valido) begin
                  op_q     <= op_in;
                  signo_q  <= signo_in;
                  neg_q    <= neg0 ^ neg1;
                  neg_r_q  <= neg0;
                  ovf_q    <= signo_in && (op_in == OP_DIV) &&
                              (Dato0 == {1'b1, {(ANCHO-1){1'b0}}}) && (&Dato1);
                  m_q      <= (op_in == OP_PRO) ? abs0 : abs1;
                  acc      <= {{ANCHO{1'b0}}, ((op_in == OP_PRO) ? abs1 : abs0)};
                  cnt      <= ANCHO_CNT'(ANCHO);
                  En_listo <= 1'b0;
                  if (itera) begin
                     estado <= CALCULO;
                  end else begin
                     estado     <= ENTREGA;
                     Sal_valido <= 1'b1;
                     Resultado  <= res_inm;
                     banderaA   <= fa_inm;
                     banderaB   <= (res_inm == '0);
                     banderaC   <= fc_inm;
                  end
               end
            end
            CALCULO: begin
               acc <= acc_nxt;
               cnt <= cnt - ANCHO_CNT'(1);
               if (cnt == ANCHO_CNT'(1)) begin
                  estado     <= ENTREGA;
                  Sal_valido <= 1'b1;
                  Resultado  <= res_it;
                  banderaA   <= fa_it;
                  banderaB   <= (res_it == '0);
                  banderaC   <= 1'b0;
               end
            end
            ENTREGA: begin
               if (Sal_listo) begin
                  estado     <= REPOSO;
                  Sal_valido <= 1'b0;
                  En_listo   <= 1'b1;
               end
            end
            default: estado <= REPOSO;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed vectors, scoreboard queue and independent
// output monitor for alu_secuencial with ANCHO=8.
module tb_alu_secuencial;
   localparam int ANCHO = 8;
   localparam int W2    = 2 * ANCHO;

   logic            Reloj = 1'b0;
   logic            Reset_n = 1'b0;
   logic [2:0]      Codigo_OP = '0;
   logic [ANCHO-1:0] Dato0 = '0, Dato1 = '0;
   logic            En_valido = 1'b0;
   logic            En_listo;
   logic [W2-1:0]   Resultado;
   logic            banderaA, banderaB, banderaC;
   logic            Sal_valido;
   logic            Sal_listo = 1'b1;
`ifdef ALU_SIGNO_EN
   logic            Con_signo = 1'b0;
`endif

   alu_secuencial #(.ANCHO(ANCHO)) dut (
      .Reloj(Reloj), .Reset_n(Reset_n), .Codigo_OP(Codigo_OP),
      .Dato0(Dato0), .Dato1(Dato1),
`ifdef ALU_SIGNO_EN
      .Con_signo(Con_signo),
`endif
      .En_valido(En_valido), .En_listo(En_listo), .Resultado(Resultado),
      .banderaA(banderaA), .banderaB(banderaB), .banderaC(banderaC),
      .Sal_valido(Sal_valido), .Sal_listo(Sal_listo)
   );

   always #5 Reloj = ~Reloj;

   int cyc = 0;
   always @(posedge Reloj) cyc <= cyc + 1;

   typedef struct {
      string         name;
      logic [W2-1:0] res;
      logic          fa, fb, fc;
      int            lat;
      int            acc_cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct packed {
      logic [2:0]  op;
      logic [7:0]  a, b;
      logic [15:0] res;
      logic        fa, fb, fc;
      logic [3:0]  lat;
   } vec_t;

   localparam vec_t TABLA [16] = '{
      '{3'd0, 8'd200,  8'd100, 16'h012C, 1'b1, 1'b0, 1'b0, 4'd1},
      '{3'd1, 8'd5,    8'd7,   16'h00FE, 1'b1, 1'b0, 1'b0, 4'd1},
      '{3'd5, 8'hF0,   8'h0F,  16'h0000, 1'b0, 1'b1, 1'b0, 4'd1},
      '{3'd2, 8'hFF,   8'hFF,  16'hFE01, 1'b1, 1'b0, 1'b0, 4'd9},
      '{3'd3, 8'd100,  8'd7,   16'h000E, 1'b0, 1'b0, 1'b0, 4'd9},
      '{3'd4, 8'd100,  8'd7,   16'h0002, 1'b0, 1'b0, 1'b0, 4'd9},
      '{3'd3, 8'd9,    8'd0,   16'h0000, 1'b0, 1'b1, 1'b1, 4'd1},
      '{3'd4, 8'd9,    8'd0,   16'h0000, 1'b0, 1'b1, 1'b1, 4'd1},
      '{3'd6, 8'hA5,   8'h5A,  16'h00FF, 1'b0, 1'b0, 1'b0, 4'd1},
      '{3'd7, 8'hFF,   8'h0F,  16'h00F0, 1'b0, 1'b0, 1'b0, 4'd1},
      '{3'd2, 8'd12,   8'd10,  16'h0078, 1'b0, 1'b0, 1'b0, 4'd9},
      '{3'd3, 8'd7,    8'd100, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd9},
      '{3'd1, 8'd7,    8'd5,   16'h0002, 1'b0, 1'b0, 1'b0, 4'd1},
      '{3'd0, 8'd0,    8'd0,   16'h0000, 1'b0, 1'b1, 1'b0, 4'd1},
      '{3'd2, 8'd16,   8'd16,  16'h0100, 1'b1, 1'b0, 1'b0, 4'd9},
      '{3'd4, 8'd255,  8'd16,  16'h000F, 1'b0, 1'b0, 1'b0, 4'd9}
   };

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: checks stability while stalled and pops the scoreboard on handoff.
   initial begin
      logic          prev_v;
      logic [W2-1:0] snap_r;
      logic [2:0]    snap_f;
      int            rise_cyc;
      exp_t          e;
      prev_v   = 1'b0;
      snap_r   = '0;
      snap_f   = '0;
      rise_cyc = 0;
      forever begin
         @(negedge Reloj);
         if (Sal_valido === 1'b1) begin
            if (!prev_v) begin
               rise_cyc = cyc;
               snap_r   = Resultado;
               snap_f   = {banderaA, banderaB, banderaC};
            end else begin
               chk("estable_res", 64'(Resultado), 64'(snap_r));
               chk("estable_flags", 64'({banderaA, banderaB, banderaC}), 64'(snap_f));
            end
            if (Sal_listo) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL salida_inesperada: got Resultado=%0h, expected no output", Resultado);
               end else begin
                  e = sb.pop_front();
                  chk({e.name, "_res"}, 64'(Resultado), 64'(e.res));
                  chk({e.name, "_flags"}, 64'({banderaA, banderaB, banderaC}),
                      64'({e.fa, e.fb, e.fc}));
                  chk({e.name, "_lat"}, 64'(rise_cyc - e.acc_cyc + 1), 64'(e.lat));
               end
            end
         end
         prev_v = (Sal_valido === 1'b1);
      end
   end

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout, expected completion", name);
   endtask

   // Present one operation, wait for acceptance and queue its expectation.
   task automatic issue(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] r, input logic fa,
                        input logic fb, input logic fc, input int lat, input bit push);
      int   t;
      exp_t e;
      t = 0;
      while (En_listo !== 1'b1 && t < 100) begin
         @(posedge Reloj); #1;
         t++;
      end
      if (t >= 100) timeout({name, "_listo"});
      Codigo_OP = op;
      Dato0     = a;
      Dato1     = b;
      En_valido = 1'b1;
      @(posedge Reloj); #1;
      En_valido = 1'b0;
      if (push) begin
         e.name = name; e.res = r; e.fa = fa; e.fb = fb; e.fc = fc;
         e.lat = lat; e.acc_cyc = cyc;
         sb.push_back(e);
      end
   endtask

   // Wait for the scoreboard to drain while scrambling the operand inputs.
   task automatic drain(input string name);
      int t;
      t = 0;
      while ((sb.size() != 0 || Sal_valido === 1'b1) && t < 200) begin
         Codigo_OP = 3'($urandom);
         Dato0     = 8'($urandom);
         Dato1     = 8'($urandom);
         @(posedge Reloj); #1;
         t++;
      end
      if (t >= 200) timeout({name, "_drain"});
   endtask

   initial begin
      repeat (2) @(posedge Reloj);
      #1;
      chk("reset_res", 64'(Resultado), 64'(0));
      chk("reset_flags", 64'({banderaA, banderaB, banderaC}), 64'(0));
      chk("reset_valido", 64'(Sal_valido), 64'(0));
      chk("reset_listo", 64'(En_listo), 64'(1));
      Reset_n = 1'b1;
      @(posedge Reloj); #1;

      for (int i = 0; i < 16; i++) begin
         issue($sformatf("v%0d", i), TABLA[i].op, TABLA[i].a, TABLA[i].b, TABLA[i].res,
               TABLA[i].fa, TABLA[i].fb, TABLA[i].fc, int'(TABLA[i].lat), 1'b1);
         drain($sformatf("v%0d", i));
      end

      // Backpressure: result held, a competing request must be ignored.
      Sal_listo = 1'b0;
      issue("bp", 3'd0, 8'd1, 8'd2, 16'h0003, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      Codigo_OP = 3'd0; Dato0 = 8'd50; Dato1 = 8'd50; En_valido = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge Reloj); #1;
         chk("bp_en_listo", 64'(En_listo), 64'(0));
         chk("bp_sal_valido", 64'(Sal_valido), 64'(1));
      end
      Sal_listo = 1'b1;
      @(posedge Reloj); #1;
      En_valido = 1'b0;
      chk("bp_fin_valido", 64'(Sal_valido), 64'(0));
      chk("bp_fin_listo", 64'(En_listo), 64'(1));
      repeat (3) @(posedge Reloj);
      #1;
      chk("bp_sin_captura", 64'(Sal_valido), 64'(0));

      // Reset during cycle 4 of a multiply: abort, no result afterwards.
      issue("rst", 3'd2, 8'd3, 8'd5, 16'h000F, 1'b0, 1'b0, 1'b0, 9, 1'b0);
      repeat (3) @(posedge Reloj);
      #1;
      Reset_n = 1'b0;
      @(posedge Reloj); #1;
      Reset_n = 1'b1;
      chk("rst_res", 64'(Resultado), 64'(0));
      chk("rst_flags", 64'({banderaA, banderaB, banderaC}), 64'(0));
      chk("rst_valido", 64'(Sal_valido), 64'(0));
      chk("rst_listo", 64'(En_listo), 64'(1));
      repeat (15) @(posedge Reloj);
      #1;
      chk("rst_sin_pulso", 64'(Sal_valido), 64'(0));

`ifdef ALU_SIGNO_EN
      Con_signo = 1'b1;
      issue("s_div", 3'd3, 8'hFA, 8'd4, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9, 1'b1);
      drain("s_div");
      issue("s_mod", 3'd4, 8'hFA, 8'd4, 16'hFFFE, 1'b0, 1'b0, 1'b0, 9, 1'b1);
      drain("s_mod");
      issue("s_ovf", 3'd3, 8'h80, 8'hFF, 16'hFF80, 1'b1, 1'b0, 1'b0, 9, 1'b1);
      drain("s_ovf");
      Con_signo = 1'b0;
`endif

      repeat (3) @(posedge Reloj);
      #1;
      chk("sb_vacio", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
